// File: rtl/block_serializer.sv
// Serialises packed BLOCK_SIZE-bit blocks into OUT_WIDTH-bit stream words, MSB first,
// trimming the final block to the words that carry valid bits and flagging its trailing bytes.
module block_serializer #(
  parameter int BLOCK_SIZE = 64,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic [BLOCK_SIZE-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic [$clog2(BLOCK_SIZE):0]   in_last_bits,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic [OUT_WIDTH/8-1:0]        out_keep,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last
);

  localparam int R   = BLOCK_SIZE / OUT_WIDTH;
  localparam int KB  = OUT_WIDTH / 8;
  localparam int LBW = $clog2(BLOCK_SIZE) + 1;
  localparam int RW  = LBW + 1;
  localparam int CW  = $clog2(R + 1);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  logic [BLOCK_SIZE-1:0] shift_q, shift_d;
  logic [CW-1:0]         words_left_q, words_left_d;
  logic                  last_q, last_d;
  logic [KB-1:0]         keep_last_q, keep_last_d;

  logic                  state;
  logic                  final_word;
  logic                  in_fire;
  logic                  out_fire;

  logic [RW-1:0]         bits_ext;
  logic [RW-1:0]         n_raw;
  logic [RW-1:0]         rem_bits;
  logic [RW-1:0]         n_bytes;
  logic [KB-1:0]         keep_mask;
  logic [CW-1:0]         load_n;
  logic [KB-1:0]         load_keep;

  assign state      = (words_left_q == '0) ? ST_EMPTY : ST_SHIFT;
  assign final_word = (words_left_q == CW'(1));

  assign out_valid  = (state == ST_SHIFT);
  assign out_data   = shift_q[BLOCK_SIZE-1 -: OUT_WIDTH];
  assign out_last   = out_valid & final_word & last_q;
  assign out_keep   = !out_valid ? '0 :
                      (final_word && last_q) ? keep_last_q : {KB{1'b1}};

  assign out_fire   = out_valid & out_ready;
  // Combinational path from out_ready lets the next block load as the last word leaves.
  assign in_ready   = aresetn & ((state == ST_EMPTY) | (out_fire & final_word));
  assign in_fire    = in_valid & in_ready;

  // Word count and byte count of the trailing word of a final block.
  assign bits_ext = {1'b0, in_last_bits};
  assign n_raw    = (bits_ext + RW'(OUT_WIDTH - 1)) / RW'(OUT_WIDTH);
  assign rem_bits = bits_ext + RW'(OUT_WIDTH) - n_raw * RW'(OUT_WIDTH);
  assign n_bytes  = (rem_bits + RW'(7)) >> 3;

  generate
    for (genvar gi = 0; gi < KB; gi++) begin : g_keep
      assign keep_mask[gi] = (n_bytes > RW'(KB - 1 - gi));
    end
  endgenerate

  always_comb begin
    load_n    = CW'(R);
    load_keep = {KB{1'b1}};
    if (in_last) begin
      if (in_last_bits == '0) begin
        load_n    = CW'(1);
        load_keep = '0;
      end else begin
        load_n    = CW'(n_raw);
        load_keep = keep_mask;
      end
    end
  end

  always_comb begin
    shift_d      = shift_q;
    words_left_d = words_left_q;
    last_d       = last_q;
    keep_last_d  = keep_last_q;
    if (in_fire) begin
      shift_d      = in_data;
      words_left_d = load_n;
      last_d       = in_last;
      keep_last_d  = load_keep;
    end else if (out_fire) begin
      shift_d      = shift_q << OUT_WIDTH;
      words_left_d = words_left_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      shift_q      <= '0;
      words_left_q <= '0;
      last_q       <= 1'b0;
      keep_last_q  <= '0;
    end else begin
      shift_q      <= shift_d;
      words_left_q <= words_left_d;
      last_q       <= last_d;
      keep_last_q  <= keep_last_d;
    end
  end

endmodule

// File: tb/tb_block_serializer.sv
// Directed vector table plus hand-written sequences (back-to-back, backpressure stream, reset)
// for block_serializer with BLOCK_SIZE=64, OUT_WIDTH=32.
module tb_block_serializer;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [6:0]  in_last_bits = '0;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  block_serializer #(.BLOCK_SIZE(64), .OUT_WIDTH(32)) dut (
    .clk(clk), .aresetn(aresetn),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_last_bits(in_last_bits),
    .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [6:0]  bits;
    int          nw;
    logic [31:0] w0, w1;
    logic [3:0]  k0, k1;
    logic        l0, l1;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Presents one block, then checks each word (out_ready high) and the idle cycle after it.
  task automatic send_and_check(input vec_t v, input string tag);
    int t;
    logic [31:0] ew;
    logic [3:0]  ek;
    logic        el;
    in_data = v.data; in_last = v.last; in_last_bits = v.bits; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin cyc(); t++; end
    chk($sformatf("%s in_ready", tag), 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < v.nw; i++) begin
      ew = (i == 0) ? v.w0 : v.w1;
      ek = (i == 0) ? v.k0 : v.k1;
      el = (i == 0) ? v.l0 : v.l1;
      chk($sformatf("%s w%0d valid", tag, i), 64'(out_valid), 64'd1);
      chk($sformatf("%s w%0d data", tag, i), 64'(out_data), 64'(ew));
      chk($sformatf("%s w%0d keep", tag, i), 64'(out_keep), 64'(ek));
      chk($sformatf("%s w%0d last", tag, i), 64'(out_last), 64'(el));
      $display("%s word %0d: data=%08h keep=%b last=%b", tag, i, out_data, out_keep, out_last);
      cyc();
    end
    chk($sformatf("%s idle valid", tag), 64'(out_valid), 64'd0);
  endtask

  logic [63:0] b2b[3];
  logic [31:0] b2b_w[6];
  logic        acc;

  logic [63:0] blk_data[100];
  logic        blk_last[100];
  logic [6:0]  blk_bits[100];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];

  initial begin
    vt[0] = '{64'h1111111122222222, 1'b0, 7'd0,  2, 32'h11111111, 32'h22222222, 4'hF, 4'hF, 1'b0, 1'b0};
    vt[1] = '{64'hAABBCCDDEE000000, 1'b1, 7'd40, 2, 32'hAABBCCDD, 32'hEE000000, 4'hF, 4'h8, 1'b0, 1'b1};
    vt[2] = '{64'h1234500000000000, 1'b1, 7'd20, 1, 32'h12345000, 32'h0,        4'hE, 4'h0, 1'b1, 1'b0};
    vt[3] = '{64'hFFFFFFFF00000000, 1'b1, 7'd0,  1, 32'hFFFFFFFF, 32'h0,        4'h0, 4'h0, 1'b1, 1'b0};
    vt[4] = '{64'h0123456789ABCDEF, 1'b0, 7'd20, 2, 32'h01234567, 32'h89ABCDEF, 4'hF, 4'hF, 1'b0, 1'b0};
    vt[5] = '{64'h0123456789ABCDEF, 1'b1, 7'd64, 2, 32'h01234567, 32'h89ABCDEF, 4'hF, 4'hF, 1'b0, 1'b1};
    vt[6] = '{64'hCAFEBABE55555555, 1'b1, 7'd32, 1, 32'hCAFEBABE, 32'h0,        4'hF, 4'h0, 1'b1, 1'b0};
    vt[7] = '{64'hCAFEBABE55555555, 1'b1, 7'd33, 2, 32'hCAFEBABE, 32'h55555555, 4'hF, 4'h8, 1'b0, 1'b1};
    vt[8] = '{64'h0102030405060708, 1'b1, 7'd49, 2, 32'h01020304, 32'h05060708, 4'hF, 4'hE, 1'b0, 1'b1};
    vt[9] = '{64'h0102030405060708, 1'b1, 7'd8,  1, 32'h01020304, 32'h0,        4'h8, 4'h0, 1'b1, 1'b0};

    // Reset state
    #3;
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_data", 64'(out_data), 64'd0);
    chk("rst out_keep", 64'(out_keep), 64'd0);
    chk("rst out_last", 64'(out_last), 64'd0);
    cyc(); cyc();
    aresetn = 1'b1;
    #1;
    chk("post-rst in_ready", 64'(in_ready), 64'd1);
    cyc();

    for (int i = 0; i < 10; i++) send_and_check(vt[i], $sformatf("vec%0d", i));

    // Back-to-back blocks with in_valid held
    b2b[0] = 64'hA0A0A0A0A1A1A1A1;
    b2b[1] = 64'hB0B0B0B0B1B1B1B1;
    b2b[2] = 64'hC0C0C0C0C1C1C1C1;
    for (int i = 0; i < 6; i++) b2b_w[i] = (i % 2 == 0) ? b2b[i/2][63:32] : b2b[i/2][31:0];
    begin
      int bi;
      bi = 0;
      in_data = b2b[0]; in_last = 1'b0; in_last_bits = '0; in_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
        if (c >= 1 && c <= 6) begin
          chk($sformatf("b2b c%0d valid", c), 64'(out_valid), 64'd1);
          chk($sformatf("b2b c%0d data", c), 64'(out_data), 64'(b2b_w[c-1]));
        end
        if (c <= 6) chk($sformatf("b2b c%0d in_ready", c), 64'(in_ready), 64'((c % 2) == 0));
        if (c == 7) chk("b2b c7 idle", 64'(out_valid), 64'd0);
        $display("b2b cycle %0d: in_ready=%b out_valid=%b data=%08h", c, in_ready, out_valid, out_data);
        acc = in_valid & in_ready;
        cyc();
        if (acc) begin
          bi++;
          if (bi < 3) in_data = b2b[bi];
          else in_valid = 1'b0;
        end
      end
    end

    // Random backpressure stream of 100 blocks
    for (int i = 0; i < 100; i++) begin
      int nb;
      blk_data[i] = {$urandom, $urandom};
      blk_last[i] = (i % 5 == 4);
      blk_bits[i] = 7'($urandom_range(0, 64));
      nb = blk_last[i] ? (int'(blk_bits[i]) + 7) / 8 : 8;
      for (int j = 0; j < nb; j++) exp_q.push_back(blk_data[i][63-8*j -: 8]);
    end
    begin
      int bi, cycles, mism;
      logic        pend, fire;
      logic [31:0] sv_data;
      logic [3:0]  sv_keep;
      logic        sv_last;
      bi = 0; cycles = 0; pend = 1'b0; acc = 1'b0;
      in_valid = 1'b0;
      while (cycles < 5000) begin
        @(posedge clk); #1;
        cycles++;
        if (acc) begin bi++; in_valid = 1'b0; end
        if (pend) begin
          chk("hold valid", 64'(out_valid), 64'd1);
          chk("hold data", 64'(out_data), 64'(sv_data));
          chk("hold keep", 64'(out_keep), 64'(sv_keep));
          chk("hold last", 64'(out_last), 64'(sv_last));
        end
        if (bi == 100 && !out_valid) break;
        out_ready = ($urandom_range(0, 1) == 1);
        if (!in_valid && bi < 100) in_valid = ($urandom_range(0, 3) != 0);
        if (bi < 100) begin
          in_data = blk_data[bi]; in_last = blk_last[bi]; in_last_bits = blk_bits[bi];
        end
        #1;
        fire = out_valid & out_ready;
        if (fire) begin
          for (int k = 3; k >= 0; k--) if (out_keep[k]) got_q.push_back(out_data[8*k +: 8]);
          $display("stream word: data=%08h keep=%b last=%b", out_data, out_keep, out_last);
        end
        pend = out_valid & !out_ready;
        sv_data = out_data; sv_keep = out_keep; sv_last = out_last;
        acc = in_valid & in_ready;
      end
      chk("stream finished in budget", 64'(cycles < 5000), 64'd1);
      out_ready = 1'b1; in_valid = 1'b0;
      chk("stream byte count", 64'(got_q.size()), 64'(exp_q.size()));
      mism = 0;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        if (got_q[i] !== exp_q[i]) mism++;
      chk("stream byte mismatches", 64'(mism), 64'd0);
    end
    cyc();

    // Reset after the first word of a block
    in_data = 64'h5A5A5A5AA5A5A5A5; in_last = 1'b0; in_last_bits = '0; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("mid-rst first word", 64'(out_data), 64'h5A5A5A5A);
    cyc();
    aresetn = 1'b0;
    #1;
    chk("mid-rst out_valid", 64'(out_valid), 64'd0);
    chk("mid-rst out_data", 64'(out_data), 64'd0);
    chk("mid-rst out_keep", 64'(out_keep), 64'd0);
    chk("mid-rst in_ready", 64'(in_ready), 64'd0);
    cyc(); cyc();
    aresetn = 1'b1;
    #1;
    chk("mid-rst release in_ready", 64'(in_ready), 64'd1);
    chk("mid-rst release out_valid", 64'(out_valid), 64'd0);
    cyc();
    send_and_check('{64'hDEADBEEFCAFEF00D, 1'b0, 7'd0, 2, 32'hDEADBEEF, 32'hCAFEF00D,
                     4'hF, 4'hF, 1'b0, 1'b0}, "after-rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
